// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: register-mapped PWM controller for 4 RGB LEDs (NumCh channels).
//
// Ports
//   clk_sys_i     system clock, all logic on its rising edge
//   rst_sys_i     asynchronous active-high reset
//   dev_req_i     bus request (already address-decoded for this block)
//   dev_we_i      write enable
//   dev_be_i      byte enables (only [1:0] are used)
//   dev_addr_i    byte address; word index = dev_addr_i[5:2]
//   dev_wdata_i   write data
//   dev_rvalid_o  response valid, one cycle after every request
//   dev_rdata_o   read data with dev_rvalid_o (zero after writes)
//   pwm_o         registered active-high PWM outputs
//
// Bus handshake: there is no ready; every cycle with dev_req_i high is one
// accepted transfer, answered by dev_rvalid_o exactly one cycle later.
//
// Register map (word index): 0..NumCh-1 DUTY[i][7:0], 12 CTRL {presc[15:8],
// en[0]}, 13 STATUS cnt[7:0] (read-only), everything else reads 0.
//
// Optional feature: define RGB_LED_PWM_PHASE_EN to offset the PWM phase of
// channel i by 20*i counts (mod 255) so the LED current edges are spread out.

module rgb_led_pwm #(
  parameter int          NumCh        = 12,
  parameter logic [7:0]  PrescDefault = 8'd99
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic             dev_req_i,
  input  logic             dev_we_i,
  input  logic [3:0]       dev_be_i,
  input  logic [31:0]      dev_addr_i,
  input  logic [31:0]      dev_wdata_i,
  output logic             dev_rvalid_o,
  output logic [31:0]      dev_rdata_o,
  output logic [NumCh-1:0] pwm_o
);

  localparam logic [3:0] WordCtrl   = 4'd12;
  localparam logic [3:0] WordStatus = 4'd13;

  logic [7:0]       r_duty_pend [NumCh];
  logic [7:0]       r_duty_act  [NumCh];
  logic             r_en;
  logic [7:0]       r_presc;
  logic [7:0]       r_psc;
  logic [7:0]       r_cnt;
  logic [NumCh-1:0] r_pwm;
  logic             r_rvalid;
  logic [31:0]      r_rdata;

  logic [3:0]  w_word;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_tick;
  logic        w_wrap;
  logic [31:0] w_rdata;
  logic [7:0]  w_phase [NumCh];
  logic        w_unused;

  assign w_word    = dev_addr_i[5:2];
  assign w_wr      = dev_req_i && dev_we_i;
  assign w_ctrl_wr = w_wr && (w_word == WordCtrl);
  assign w_tick    = r_en && (r_psc == r_presc);
  // Last tick of a 255-tick period: the only point active duties may change.
  assign w_wrap    = w_tick && (r_cnt == 8'd254);

  assign w_unused = ^{dev_addr_i[31:6], dev_addr_i[1:0],
                      dev_wdata_i[31:16], dev_be_i[3:2]};

  // Prescaler, period counter and CTRL register.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_en    <= 1'b0;
      r_presc <= PrescDefault;
      r_psc   <= 8'd0;
      r_cnt   <= 8'd0;
    end else begin
      if (w_ctrl_wr) begin
        if (dev_be_i[0]) r_en    <= dev_wdata_i[0];
        if (dev_be_i[1]) r_presc <= dev_wdata_i[15:8];
      end
      // A CTRL write restarts the period so a new presc takes effect cleanly.
      if (!r_en || w_ctrl_wr) begin
        r_psc <= 8'd0;
        r_cnt <= 8'd0;
      end else if (w_tick) begin
        r_psc <= 8'd0;
        r_cnt <= (r_cnt == 8'd254) ? 8'd0 : r_cnt + 8'd1;
      end else begin
        r_psc <= r_psc + 8'd1;
      end
    end
  end

  // Duty registers: writes land in pending; active follows pending only at
  // the period wrap (or continuously while disabled). A write coinciding with
  // the wrap goes straight into active as well.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < NumCh; i++) begin
        r_duty_pend[i] <= 8'd0;
        r_duty_act[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (w_wr && dev_be_i[0] && (w_word == 4'(i))) begin
          r_duty_pend[i] <= dev_wdata_i[7:0];
          if (w_wrap || !r_en) r_duty_act[i] <= dev_wdata_i[7:0];
        end else if (w_wrap || !r_en) begin
          r_duty_act[i] <= r_duty_pend[i];
        end
      end
    end
  end

  // Per-channel phase of the shared period counter.
  for (genvar gi = 0; gi < NumCh; gi++) begin : g_phase
`ifdef RGB_LED_PWM_PHASE_EN
    localparam int Off = (20 * gi) % 255;
    logic [8:0] w_sum;
    assign w_sum         = {1'b0, r_cnt} + 9'(Off);
    assign w_phase[gi]   = (w_sum >= 9'd255) ? 8'(w_sum - 9'd255) : w_sum[7:0];
`else
    assign w_phase[gi]   = r_cnt;
`endif
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        r_pwm[i] <= r_en && (w_phase[i] < r_duty_act[i]);
      end
    end
  end

  // Read mux.
  always_comb begin
    w_rdata = 32'd0;
    for (int i = 0; i < NumCh; i++) begin
      if (w_word == 4'(i)) w_rdata = {24'd0, r_duty_pend[i]};
    end
    if (w_word == WordCtrl)   w_rdata = {16'd0, r_presc, 7'd0, r_en};
    if (w_word == WordStatus) w_rdata = {24'd0, r_cnt};
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rvalid <= dev_req_i;
      r_rdata  <= (dev_req_i && !dev_we_i) ? w_rdata : 32'd0;
    end
  end

  assign dev_rvalid_o = r_rvalid;
  assign dev_rdata_o  = r_rdata;
  assign pwm_o        = r_pwm;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm: self-checking bench for rgb_led_pwm (register access table,
// PWM period/duty sequences, update-at-wrap, phase offset, async reset).

module tb_rgb_led_pwm;

  localparam int NUM_CH = 12;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dev_req = 1'b0;
  logic              dev_we = 1'b0;
  logic [3:0]        dev_be = 4'd0;
  logic [31:0]       dev_addr = 32'd0;
  logic [31:0]       dev_wdata = 32'd0;
  logic              dev_rvalid;
  logic [31:0]       dev_rdata;
  logic [NUM_CH-1:0] pwm;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  rgb_led_pwm #(.NumCh(NUM_CH), .PrescDefault(8'd99)) dut (
    .clk_sys_i   (clk),
    .rst_sys_i   (rst),
    .dev_req_i   (dev_req),
    .dev_we_i    (dev_we),
    .dev_be_i    (dev_be),
    .dev_addr_i  (dev_addr),
    .dev_wdata_i (dev_wdata),
    .dev_rvalid_o(dev_rvalid),
    .dev_rdata_o (dev_rdata),
    .pwm_o       (pwm)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dev_rvalid) begin
      if (exp_q.size() == 0) check("rvalid_spurious", 32'd1, 32'd0);
      else check("rdata", dev_rdata, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic bus_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp);
    @(posedge clk); #1;
    dev_req = 1'b1; dev_we = we; dev_be = be; dev_addr = addr; dev_wdata = wd;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    dev_req = 1'b0; dev_we = 1'b0; dev_be = 4'd0; dev_addr = 32'd0; dev_wdata = 32'd0;
    check("rvalid_lat", {31'd0, dev_rvalid}, 32'd1);
  endtask

  task automatic wr(input logic [3:0] word, input logic [3:0] be, input logic [31:0] wd);
    bus_xfer(1'b1, be, {26'd0, word, 2'b00}, wd, 32'd0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- pwm recorder ----------------
  logic [NUM_CH-1:0] rec [2048];
  int rec_n  = 0;
  bit rec_on = 1'b0;

  always @(negedge clk) begin
    if (rec_on && rec_n < 2048) begin
      rec[rec_n] = pwm;
      rec_n++;
    end
  end

  function automatic int find_rise(input int ch, input int from);
    for (int k = (from < 1) ? 1 : from; k < rec_n; k++)
      if (rec[k][ch] && !rec[k-1][ch]) return k;
    return -1;
  endfunction

  function automatic int run_len(input int ch, input int idx);
    int n = 0;
    if (idx < 0) return -1;
    for (int k = idx; k < rec_n && rec[k][ch]; k++) n++;
    return n;
  endfunction

  task automatic rec_start();
    rec_n = 0;
    rec_on = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vtab[23];

  initial begin
    int r0, r1, r2, n3, n4, hit;
    int gap_exp;

    vtab[0]  = '{1'b0, 4'hF, 32'h0000_0030, 32'h0,          32'h0000_6300};
    vtab[1]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,          32'h0};
    vtab[2]  = '{1'b0, 4'hF, 32'h0000_0034, 32'h0,          32'h0};
    vtab[3]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1234_56AB,  32'h0};
    vtab[4]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,          32'h0000_00AB};
    vtab[5]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0000_0077,  32'h0};
    vtab[6]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h0,          32'h0};
    vtab[7]  = '{1'b1, 4'h2, 32'h0000_0030, 32'hFFFF_5A01,  32'h0};
    vtab[8]  = '{1'b0, 4'hF, 32'h0000_0030, 32'h0,          32'h0000_5A00};
    vtab[9]  = '{1'b1, 4'h3, 32'h0000_0030, 32'h0000_3300,  32'h0};
    vtab[10] = '{1'b0, 4'hF, 32'h0000_0030, 32'h0,          32'h0000_3300};
    vtab[11] = '{1'b1, 4'hF, 32'h0000_0038, 32'hFFFF_FFFF,  32'h0};
    vtab[12] = '{1'b0, 4'hF, 32'h0000_0038, 32'h0,          32'h0};
    vtab[13] = '{1'b0, 4'hF, 32'h0000_003C, 32'h0,          32'h0};
    vtab[14] = '{1'b1, 4'h1, 32'hFFFF_FF2C, 32'h0000_00C8,  32'h0};
    vtab[15] = '{1'b0, 4'hF, 32'h0000_002C, 32'h0,          32'h0000_00C8};
    vtab[16] = '{1'b1, 4'hF, 32'h0000_0034, 32'h0000_00FF,  32'h0};
    vtab[17] = '{1'b0, 4'hF, 32'h0000_0034, 32'h0,          32'h0};
    vtab[18] = '{1'b1, 4'h2, 32'h0000_0008, 32'h0000_1100,  32'h0};
    vtab[19] = '{1'b0, 4'hF, 32'h0000_0008, 32'h0,          32'h0};
    vtab[20] = '{1'b0, 4'hF, 32'h0000_0040, 32'h0,          32'h0000_00AB};
    vtab[21] = '{1'b1, 4'h1, 32'h0000_0004, 32'h0000_FF42,  32'h0};
    vtab[22] = '{1'b0, 4'hF, 32'h0000_0004, 32'h0,          32'h0000_0042};

    // reset state
    wait_cyc(3);
    @(negedge clk);
    check("reset_pwm",    32'(pwm), 32'd0);
    check("reset_rvalid", {31'd0, dev_rvalid}, 32'd0);
    check("reset_rdata",  dev_rdata, 32'd0);
    rst = 1'b0;
    wait_cyc(2);

    // register access table (en=0 throughout)
    for (int i = 0; i < 23; i++)
      bus_xfer(vtab[i].we, vtab[i].be, vtab[i].addr, vtab[i].wdata, vtab[i].exp);
    @(negedge clk);
    check("pwm_disabled", 32'(pwm), 32'd0);

    // duty 64 period/width, duty 0 always low, duty 255 always high
    wr(4'd0, 4'h1, 32'd64);
    wr(4'd3, 4'h1, 32'd0);
    wr(4'd4, 4'h1, 32'd255);
    wr(4'd12, 4'h3, 32'h0000_0001);
    wait_cyc(5);
    rec_start();
    wait_cyc(1020);
    rec_on = 1'b0;
    r0 = find_rise(0, 1);
    r1 = find_rise(0, r0 + 1);
    r2 = find_rise(0, r1 + 1);
    check("d64_period1", 32'(r1 - r0), 32'd255);
    check("d64_period2", 32'(r2 - r1), 32'd255);
    check("d64_high",    32'(run_len(0, r0)), 32'd64);
    n3 = 0; n4 = 0;
    for (int k = 0; k < 1000; k++) begin
      if (rec[k][3])  n3++;
      if (!rec[k][4]) n4++;
    end
    check("d0_high_cnt",  32'(n3), 32'd0);
    check("d255_low_cnt", 32'(n4), 32'd0);

    // duty 200 -> 10 written mid-period: change appears only after wrap
    wr(4'd0, 4'h1, 32'd200);
    wr(4'd12, 4'h1, 32'h0);
    wait_cyc(2);
    rec_start();
    wr(4'd12, 4'h1, 32'h1);
    wait_cyc(47);
    wr(4'd0, 4'h1, 32'd10);
    wait_cyc(600);
    rec_on = 1'b0;
    r0 = find_rise(0, 1);
    r1 = find_rise(0, r0 + 1);
    check("upd_old_high", 32'(run_len(0, r0)), 32'd200);
    check("upd_period",   32'(r1 - r0), 32'd255);
    check("upd_new_high", 32'(run_len(0, r1)), 32'd10);

    // phase offset between channel 0 and 1, all duties 128
    for (int i = 0; i < NUM_CH; i++) wr(4'(i), 4'h1, 32'd128);
    wr(4'd12, 4'h1, 32'h0);
    wait_cyc(2);
    rec_start();
    wr(4'd12, 4'h1, 32'h1);
    wait_cyc(600);
    rec_on = 1'b0;
`ifdef RGB_LED_PWM_PHASE_EN
    gap_exp = 235;
`else
    gap_exp = 255;
`endif
    r0 = find_rise(0, 1);
    r1 = find_rise(1, r0 + 1);
    check("d128_high",  32'(run_len(0, r0)), 32'd128);
    check("phase_gap",  32'(r1 - r0), 32'(gap_exp));

    // asynchronous reset in mid-period
    hit = 0;
    for (int k = 0; k < 300 && hit == 0; k++) begin
      @(negedge clk);
      if (pwm != '0) hit = 1;
    end
    check("pwm_active_before_rst", 32'(hit), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_pwm",    32'(pwm), 32'd0);
    check("rst_async_rvalid", {31'd0, dev_rvalid}, 32'd0);
    wait_cyc(2);
    @(negedge clk);
    rst = 1'b0;
    bus_xfer(1'b0, 4'hF, 32'h30, 32'h0, 32'h0000_6300);
    bus_xfer(1'b0, 4'hF, 32'h00, 32'h0, 32'h0);
    bus_xfer(1'b0, 4'hF, 32'h04, 32'h0, 32'h0);
    bus_xfer(1'b0, 4'hF, 32'h2C, 32'h0, 32'h0);
    bus_xfer(1'b0, 4'hF, 32'h34, 32'h0, 32'h0);
    bus_xfer(1'b0, 4'hF, 32'h38, 32'h0, 32'h0);
    wait_cyc(3);
    @(negedge clk);
    check("pwm_after_rst", 32'(pwm), 32'd0);
    check("resp_drain",    32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
